// File: rtl/ram_ctrl.sv
// DRAM/ROM controller for the 68000-bus accelerator: row/column address mux,
// nRAS/nCAS sequencing for RAM cycles and CAS-before-RAS refresh, ROM strobes.
module ram_ctrl #(
  parameter int TRP_CYC     = 1,
  parameter int REF_RAS_CYC = 2
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic [20:0] A,
  input  logic        nWE,
  input  logic        nAS,
  input  logic        nLDS,
  input  logic        nUDS,
  input  logic        CACT,
  input  logic        RAMCS,
  input  logic        ROMCS,
  input  logic        RefReq,
  input  logic        RefUrgent,
  output logic        Ready,
  output logic        RefAck,
  output logic [11:0] RA,
  output logic        nRAS,
  output logic        nCAS,
  output logic        nLWE,
  output logic        nUWE,
  output logic        nOE,
  output logic        nROMCS,
  output logic        nROMWE
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RAS   = 3'd1;
  localparam logic [2:0] S_CAS   = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_PRE   = 3'd4;
  localparam logic [2:0] S_REFC  = 3'd5;
  localparam logic [2:0] S_REFR  = 3'd6;

  localparam logic [3:0] TRP_LOAD = 4'(TRP_CYC - 1);
  localparam logic [3:0] REF_LOAD = 4'(REF_RAS_CYC - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       nras_q, nras_d;
  logic       ncas_q, ncas_d;
  logic       ack_q, ack_d;
  logic       done_q, done_d;
  logic       col;
  logic       ramgo;

  // done blocks a second access from the same CPU cycle once CAS has been reached
  assign ramgo = CACT & RAMCS & ~done_q;
  assign col   = (state_q == S_CAS) | (state_q == S_HOLD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nras_d  = nras_q;
    ncas_d  = ncas_q;
    ack_d   = 1'b0;
    done_d  = done_q;
    if (!CACT) done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // urgent refresh preempts a pending access; a plain request yields to it
        if (RefUrgent | (RefReq & ~ramgo)) begin
          state_d = S_REFC;
          ncas_d  = 1'b0;
        end else if (ramgo) begin
          state_d = S_RAS;
          nras_d  = 1'b0;
        end
      end
      S_RAS: begin
        state_d = S_CAS;
        ncas_d  = 1'b0;
        done_d  = 1'b1;
      end
      S_CAS: state_d = S_HOLD;
      S_HOLD: begin
        if (!CACT) begin
          state_d = S_PRE;
          nras_d  = 1'b1;
          ncas_d  = 1'b1;
          cnt_d   = TRP_LOAD;
        end
      end
      S_REFC: begin
        state_d = S_REFR;
        nras_d  = 1'b0;
        cnt_d   = REF_LOAD;
      end
      S_REFR: begin
        if (cnt_q == 4'd0) begin
          state_d = S_PRE;
          nras_d  = 1'b1;
          ncas_d  = 1'b1;
          ack_d   = 1'b1;
          cnt_d   = TRP_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_PRE: begin
        if (cnt_q == 4'd0) state_d = S_IDLE;
        else cnt_d = cnt_q - 4'd1;
      end
      default: begin
        state_d = S_IDLE;
        nras_d  = 1'b1;
        ncas_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      nras_q  <= 1'b1;
      ncas_q  <= 1'b1;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nras_q  <= nras_d;
      ncas_q  <= ncas_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  assign nRAS   = nras_q;
  assign nCAS   = ncas_q;
  assign RefAck = ack_q;
  assign RA     = col ? {3'b000, A[8:0]} : A[20:9];
  assign Ready  = ~RAMCS | col;
  assign nLWE   = ~(~nWE & ~nLDS & col);
  assign nUWE   = ~(~nWE & ~nUDS & col);
  assign nOE    = ~(~nAS & nWE);
  assign nROMCS = ~(ROMCS & ~nAS);
  assign nROMWE = ~(ROMCS & ~nAS & ~nWE);

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_ram_ctrl;
  logic        CLK, nRESET;
  logic [20:0] A;
  logic        nWE, nAS, nLDS, nUDS, CACT, RAMCS, ROMCS, RefReq, RefUrgent;
  logic        Ready, RefAck, nRAS, nCAS, nLWE, nUWE, nOE, nROMCS, nROMWE;
  logic [11:0] RA;
  int checks = 0;
  int errors = 0;

  ram_ctrl #(.TRP_CYC(1), .REF_RAS_CYC(2)) dut (
    .CLK(CLK), .nRESET(nRESET), .A(A), .nWE(nWE), .nAS(nAS), .nLDS(nLDS),
    .nUDS(nUDS), .CACT(CACT), .RAMCS(RAMCS), .ROMCS(ROMCS), .RefReq(RefReq),
    .RefUrgent(RefUrgent), .Ready(Ready), .RefAck(RefAck), .RA(RA), .nRAS(nRAS),
    .nCAS(nCAS), .nLWE(nLWE), .nUWE(nUWE), .nOE(nOE), .nROMCS(nROMCS), .nROMWE(nROMWE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(negedge CLK);
  endtask

  task automatic idle_inputs;
    A = 21'd0; nWE = 1'b1; nAS = 1'b1; nLDS = 1'b1; nUDS = 1'b1; CACT = 1'b0;
    RAMCS = 1'b0; ROMCS = 1'b0; RefReq = 1'b0; RefUrgent = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    nRESET = 1'b0;
    tick(); tick();
    checks++; if ({nRAS, nCAS, RefAck, Ready} !== 4'b1101) begin errors++;
      $display("FAIL reset_strobes got %b exp %b", {nRAS, nCAS, RefAck, Ready}, 4'b1101); end
    checks++; if ({nROMCS, nOE, nROMWE} !== 3'b111) begin errors++;
      $display("FAIL reset_rom got %b exp %b", {nROMCS, nOE, nROMWE}, 3'b111); end
    nRESET = 1'b1;
    tick();
    checks++; if ({nRAS, nCAS, RefAck} !== 3'b110) begin errors++;
      $display("FAIL reset_release got %b exp %b", {nRAS, nCAS, RefAck}, 3'b110); end
  endtask

  // ROM read with an urgent refresh running underneath it
  task automatic test_rom_refresh;
    logic [2:0] exp_dram [5];
    exp_dram = '{3'b100, 3'b000, 3'b000, 3'b111, 3'b110};
    A = 21'd8195; ROMCS = 1'b1; nAS = 1'b0; nLDS = 1'b0; nUDS = 1'b0; nWE = 1'b1; CACT = 1'b1;
    #1;
    checks++; if ({nROMCS, nOE, nROMWE, Ready, nRAS} !== 5'b00111) begin errors++;
      $display("FAIL rom_read got %b exp %b", {nROMCS, nOE, nROMWE, Ready, nRAS}, 5'b00111); end
    checks++; if (RA !== 12'h010) begin errors++;
      $display("FAIL rom_ra got %h exp %h", RA, 12'h010); end
    tick();
    checks++; if ({nRAS, nCAS} !== 2'b11) begin errors++;
      $display("FAIL rom_no_dram got %b exp %b", {nRAS, nCAS}, 2'b11); end
    RefUrgent = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if ({nRAS, nCAS, RefAck} !== exp_dram[i]) begin errors++;
        $display("FAIL romref_dram_%0d got %b exp %b", i, {nRAS, nCAS, RefAck}, exp_dram[i]); end
      checks++; if ({nROMCS, nOE, nROMWE, Ready} !== 4'b0011) begin errors++;
        $display("FAIL romref_rom_%0d got %b exp %b", i, {nROMCS, nOE, nROMWE, Ready}, 4'b0011); end
      if (i == 3) RefUrgent = 1'b0;
    end
    nWE = 1'b0;
    #1;
    checks++; if ({nROMCS, nOE, nROMWE} !== 3'b010) begin errors++;
      $display("FAIL rom_write got %b exp %b", {nROMCS, nOE, nROMWE}, 3'b010); end
    idle_inputs();
    tick();
  endtask

  task automatic test_ram_write;
    A = 21'd8195; RAMCS = 1'b1; nWE = 1'b0; nLDS = 1'b0; nUDS = 1'b1; nAS = 1'b0; CACT = 1'b1;
    #1;
    checks++; if (Ready !== 1'b0) begin errors++;
      $display("FAIL ramw_ready_idle got %b exp %b", Ready, 1'b0); end
    tick();
    checks++; if ({nRAS, nCAS, Ready, RA} !== {3'b010, 12'h010}) begin errors++;
      $display("FAIL ramw_ras got %b/%h exp 010/010", {nRAS, nCAS, Ready}, RA); end
    tick();
    checks++; if ({nRAS, nCAS, Ready, RA} !== {3'b001, 12'h003}) begin errors++;
      $display("FAIL ramw_cas got %b/%h exp 001/003", {nRAS, nCAS, Ready}, RA); end
    checks++; if ({nLWE, nUWE} !== 2'b01) begin errors++;
      $display("FAIL ramw_we got %b exp %b", {nLWE, nUWE}, 2'b01); end
    tick();
    checks++; if ({nRAS, nCAS, Ready, nLWE, nUWE} !== 5'b00101) begin errors++;
      $display("FAIL ramw_hold got %b exp %b", {nRAS, nCAS, Ready, nLWE, nUWE}, 5'b00101); end
    idle_inputs();
    tick();
    checks++; if ({nRAS, nCAS, nLWE, nUWE, RefAck} !== 5'b11110) begin errors++;
      $display("FAIL ramw_pre got %b exp %b", {nRAS, nCAS, nLWE, nUWE, RefAck}, 5'b11110); end
    tick();
    checks++; if ({nRAS, nCAS} !== 2'b11) begin errors++;
      $display("FAIL ramw_idle got %b exp %b", {nRAS, nCAS}, 2'b11); end
  endtask

  // RefReq and a RAM start in the same idle clock: access first, then refresh
  task automatic test_back_to_back;
    logic [2:0] exp_s [10];
    int acks;
    exp_s = '{3'b010, 3'b000, 3'b000, 3'b110, 3'b110,
              3'b100, 3'b000, 3'b000, 3'b111, 3'b110};
    acks = 0;
    A = 21'h0ABCD; RAMCS = 1'b1; CACT = 1'b1; nAS = 1'b0; nWE = 1'b0; nUDS = 1'b0; nLDS = 1'b1;
    RefReq = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (RefAck === 1'b1) acks++;
      checks++; if ({nRAS, nCAS, RefAck} !== exp_s[i]) begin errors++;
        $display("FAIL b2b_step_%0d got %b exp %b", i, {nRAS, nCAS, RefAck}, exp_s[i]); end
      if (i == 0) begin
        checks++; if (RA !== 12'h055) begin errors++;
          $display("FAIL b2b_row got %h exp %h", RA, 12'h055); end
      end
      if (i == 1) begin
        checks++; if ({RA, nLWE, nUWE} !== {12'h1CD, 2'b10}) begin errors++;
          $display("FAIL b2b_col got %h/%b exp 1cd/10", RA, {nLWE, nUWE}); end
        CACT = 1'b0; nAS = 1'b1; RAMCS = 1'b0; nWE = 1'b1; nUDS = 1'b1;
      end
      if (i == 8) RefReq = 1'b0;
    end
    checks++; if (acks !== 1) begin errors++;
      $display("FAIL b2b_ack_count got %0d exp %0d", acks, 1); end
    idle_inputs();
  endtask

  // RefUrgent with a RAM start pending: refresh runs first, Ready held low
  task automatic test_urgent_preempt;
    logic [3:0] exp_s [10];
    exp_s = '{4'b1000, 4'b0000, 4'b0000, 4'b1110, 4'b1100,
              4'b0100, 4'b0001, 4'b0001, 4'b1101, 4'b1101};
    A = 21'd8195; RAMCS = 1'b1; CACT = 1'b1; nAS = 1'b0; nWE = 1'b1; nLDS = 1'b0; nUDS = 1'b0;
    RefUrgent = 1'b1;
    #1;
    checks++; if ({Ready, nOE} !== 2'b00) begin errors++;
      $display("FAIL urg_start got %b exp %b", {Ready, nOE}, 2'b00); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if ({nRAS, nCAS, RefAck, Ready} !== exp_s[i]) begin errors++;
        $display("FAIL urg_step_%0d got %b exp %b", i, {nRAS, nCAS, RefAck, Ready}, exp_s[i]); end
      if (i == 3) RefUrgent = 1'b0;
      if (i == 6) begin CACT = 1'b0; nAS = 1'b1; RAMCS = 1'b0; end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid;
    A = 21'd8195; RAMCS = 1'b1; CACT = 1'b1; nAS = 1'b0; nWE = 1'b1;
    tick(); tick();
    checks++; if ({nRAS, nCAS} !== 2'b00) begin errors++;
      $display("FAIL rmid_pre got %b exp %b", {nRAS, nCAS}, 2'b00); end
    #2 nRESET = 1'b0;
    #1;
    checks++; if ({nRAS, nCAS, RefAck, RA} !== {3'b110, 12'h010}) begin errors++;
      $display("FAIL rmid_async got %b/%h exp 110/010", {nRAS, nCAS, RefAck}, RA); end
    idle_inputs();
    tick();
    nRESET = 1'b1;
    tick(); tick();
    checks++; if ({nRAS, nCAS, RefAck} !== 3'b110) begin errors++;
      $display("FAIL rmid_after got %b exp %b", {nRAS, nCAS, RefAck}, 3'b110); end
  endtask

  initial begin
    test_reset();
    test_rom_refresh();
    test_ram_write();
    test_back_to_back();
    test_urgent_preempt();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
